// File: rtl/br_resolve_ctrl_pkg.sv
// Shared defaults, state encoding and entry layout for the branch resolve controller.
package br_resolve_ctrl_pkg;

    localparam int BR_QUEUE_DEPTH = 4;
    localparam int BR_QUEUE_AW    = 2;
    localparam int PERF_CNT_WIDTH = 32;

    typedef logic [31:0] reg_t;

    typedef enum logic [1:0] {
        BRC_IDLE     = 2'd0,
        BRC_FLUSH    = 2'd1,
        BRC_REDIRECT = 2'd2
    } brc_state_t;

    typedef struct packed {
        reg_t pc;
        logic taken;
    } upd_entry_t;

    localparam int UPD_ENTRY_W = $bits(upd_entry_t);

endpackage

// File: rtl/br_upd_fifo.sv
// Synchronous FIFO for predictor training updates; every push/pop is qualified by rdy.
module br_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = rdy && push && !full;
    assign pop_en  = rdy && pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            if (push_en && !pop_en)      count <= count + (AW+1)'(1);
            else if (pop_en && !push_en) count <= count - (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; empty comes from count, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/br_resolve_ctrl.sv
// Queues committed branch outcomes for predictor training and sequences the
// flush/redirect toward fetch after a misprediction.
module br_resolve_ctrl
    import br_resolve_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = BR_QUEUE_DEPTH,
    parameter int QUEUE_AW    = BR_QUEUE_AW,
    parameter int CNT_WIDTH   = PERF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 commit_valid,
    input  logic [31:0]          commit_pc,
    input  logic                 commit_is_br,
    input  logic                 commit_taken,
    input  logic                 commit_pred_taken,
    input  logic [31:0]          commit_next_pc,
    output logic                 stall_to_rob,
    input  logic                 upd_ready,
    output logic                 upd_valid,
    output logic [31:0]          upd_pc,
    output logic                 upd_taken,
    output logic                 flush_out,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 fetch_ack,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] mispred_count
);

    brc_state_t state_q, state_d;
    upd_entry_t push_entry, head_entry;
    logic       fifo_full, fifo_empty;
    logic       accept, br_accept, mispredict;
    reg_t       redirect_pc_q;

    assign stall_to_rob = fifo_full || (state_q != BRC_IDLE);
    assign accept       = rdy && commit_valid && !stall_to_rob;
    assign br_accept    = accept && commit_is_br;
    assign mispredict   = br_accept && (commit_taken != commit_pred_taken);

    assign push_entry = '{pc: commit_pc, taken: commit_taken};

    br_upd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .AW    (QUEUE_AW),
        .WIDTH (UPD_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .push  (br_accept),
        .pop   (upd_ready),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_entry)
    );

    assign upd_valid = !fifo_empty;
    assign upd_pc    = head_entry.pc;
    assign upd_taken = head_entry.taken;

    // NOTE: the default assignment first means every path assigns state_d, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BRC_IDLE:     if (mispredict)       state_d = BRC_FLUSH;
            BRC_FLUSH:    if (rdy)              state_d = BRC_REDIRECT;
            BRC_REDIRECT: if (rdy && fetch_ack) state_d = BRC_IDLE;
            default:                            state_d = BRC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BRC_IDLE;
            redirect_pc_q <= '0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            state_q <= state_d;
            if (br_accept)  br_count      <= br_count + CNT_WIDTH'(1);
            if (mispredict) begin
                mispred_count <= mispred_count + CNT_WIDTH'(1);
                redirect_pc_q <= commit_next_pc;
            end
        end
    end

    // Both outputs decode the state register directly, so they are glitch-free
    // and drop together with the asynchronous reset.
    assign flush_out      = (state_q == BRC_FLUSH);
    assign redirect_valid = (state_q == BRC_REDIRECT);
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed self-checking bench for br_resolve_ctrl: reset, training queue, mispredict
// sequencing, full/stall, concurrent push/pop, rdy gating and reset mid-redirect.
module tb_br_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_is_br;
    logic        commit_taken;
    logic        commit_pred_taken;
    logic [31:0] commit_next_pc;
    logic        stall_to_rob;
    logic        upd_ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_ack;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int passed = 0;
    int total  = 0;

    br_resolve_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .commit_valid      (commit_valid),
        .commit_pc         (commit_pc),
        .commit_is_br      (commit_is_br),
        .commit_taken      (commit_taken),
        .commit_pred_taken (commit_pred_taken),
        .commit_next_pc    (commit_next_pc),
        .stall_to_rob      (stall_to_rob),
        .upd_ready         (upd_ready),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .flush_out         (flush_out),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_ack         (fetch_ack),
        .br_count          (br_count),
        .mispred_count     (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_commit(input logic [31:0] pc, input logic taken, input logic pred,
                                input logic [31:0] next_pc);
        commit_valid      = 1'b1;
        commit_is_br      = 1'b1;
        commit_pc         = pc;
        commit_taken      = taken;
        commit_pred_taken = pred;
        commit_next_pc    = next_pc;
    endtask

    logic [31:0] seq_pc [8];

    initial begin
        rst = 1'b0; rdy = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_is_br = 1'b0;
        commit_taken = 1'b0; commit_pred_taken = 1'b0; commit_next_pc = '0;
        upd_ready = 1'b0; fetch_ack = 1'b0;

        // Reset state
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_stall", 32'(stall_to_rob), 32'd0);
        check("rst_flush", 32'(flush_out), 32'd0);
        check("rst_redirect", 32'(redirect_valid), 32'd0);
        check("rst_br_count", br_count, 32'd0);
        check("rst_mispred", mispred_count, 32'd0);

        // Correctly predicted branch
        upd_ready = 1'b1;
        drive_commit(32'h100, 1'b1, 1'b1, 32'h104);
        tick();
        commit_valid = 1'b0;
        check("ok_upd_valid", 32'(upd_valid), 32'd1);
        check("ok_upd_pc", upd_pc, 32'h100);
        check("ok_upd_taken", 32'(upd_taken), 32'd1);
        check("ok_br_count", br_count, 32'd1);
        check("ok_mispred", mispred_count, 32'd0);
        check("ok_flush", 32'(flush_out), 32'd0);
        tick();
        check("ok_upd_drained", 32'(upd_valid), 32'd0);
        check("ok_flush2", 32'(flush_out), 32'd0);

        // Non-branch commit: no push, no count
        commit_valid = 1'b1; commit_is_br = 1'b0; commit_pc = 32'h180;
        commit_taken = 1'b0; commit_pred_taken = 1'b1;
        tick();
        commit_valid = 1'b0;
        check("nb_upd_valid", 32'(upd_valid), 32'd0);
        check("nb_br_count", br_count, 32'd1);
        check("nb_flush", 32'(flush_out), 32'd0);

        // Mispredict at T; flush at T+1, redirect from T+2 through the ack cycle
        drive_commit(32'h200, 1'b0, 1'b1, 32'h204);
        tick();
        commit_valid = 1'b0;
        check("mp_flush_t1", 32'(flush_out), 32'd1);
        check("mp_redir_t1", 32'(redirect_valid), 32'd0);
        check("mp_stall_t1", 32'(stall_to_rob), 32'd1);
        check("mp_count", mispred_count, 32'd1);
        check("mp_br_count", br_count, 32'd2);
        check("mp_upd_pc", upd_pc, 32'h200);
        check("mp_upd_taken", 32'(upd_taken), 32'd0);
        tick();
        check("mp_flush_t2", 32'(flush_out), 32'd0);
        check("mp_redir_t2", 32'(redirect_valid), 32'd1);
        check("mp_redir_pc_t2", redirect_pc, 32'h204);
        check("mp_stall_t2", 32'(stall_to_rob), 32'd1);
        check("mp_drained", 32'(upd_valid), 32'd0);
        // A commit while stalled is ignored
        drive_commit(32'h300, 1'b1, 1'b0, 32'h999);
        tick();
        commit_valid = 1'b0;
        check("mp_redir_t3", 32'(redirect_valid), 32'd1);
        check("mp_ignored_br", br_count, 32'd2);
        check("mp_ignored_mp", mispred_count, 32'd1);
        check("mp_ignored_push", 32'(upd_valid), 32'd0);
        check("mp_redir_pc_t3", redirect_pc, 32'h204);
        tick();
        check("mp_redir_t4", 32'(redirect_valid), 32'd1);
        fetch_ack = 1'b1;
        check("mp_redir_ack", 32'(redirect_valid), 32'd1);
        check("mp_stall_ack", 32'(stall_to_rob), 32'd1);
        tick();
        fetch_ack = 1'b0;
        check("mp_redir_done", 32'(redirect_valid), 32'd0);
        check("mp_stall_done", 32'(stall_to_rob), 32'd0);
        check("mp_flush_done", 32'(flush_out), 32'd0);

        // FIFO full: four pushes with the predictor blocked
        upd_ready = 1'b0;
        drive_commit(32'h10, 1'b1, 1'b1, 32'h0); tick();
        check("full_stall1", 32'(stall_to_rob), 32'd0);
        drive_commit(32'h20, 1'b0, 1'b0, 32'h0); tick();
        drive_commit(32'h30, 1'b1, 1'b1, 32'h0); tick();
        check("full_stall3", 32'(stall_to_rob), 32'd0);
        drive_commit(32'h40, 1'b1, 1'b1, 32'h0); tick();
        check("full_stall4", 32'(stall_to_rob), 32'd1);
        check("full_head", upd_pc, 32'h10);
        drive_commit(32'h50, 1'b0, 1'b1, 32'h77); tick();
        commit_valid = 1'b0;
        check("full_5th_ignored", br_count, 32'd6);
        check("full_5th_no_mp", mispred_count, 32'd1);
        check("full_5th_no_flush", 32'(flush_out), 32'd0);
        check("full_still", 32'(stall_to_rob), 32'd1);
        upd_ready = 1'b1;
        tick();
        check("drain_stall", 32'(stall_to_rob), 32'd0);
        check("drain_pc2", upd_pc, 32'h20);
        check("drain_tk2", 32'(upd_taken), 32'd0);
        tick();
        check("drain_pc3", upd_pc, 32'h30);
        check("drain_tk3", 32'(upd_taken), 32'd1);
        tick();
        check("drain_pc4", upd_pc, 32'h40);
        tick();
        check("drain_empty", 32'(upd_valid), 32'd0);

        // Concurrent push/pop with two entries held
        for (int i = 0; i < 8; i++) seq_pc[i] = 32'hA0 + 32'(i) * 32'h10;
        upd_ready = 1'b0;
        drive_commit(seq_pc[0], 1'b1, 1'b1, 32'h0); tick();
        drive_commit(seq_pc[1], 1'b0, 1'b0, 32'h0); tick();
        upd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_commit(seq_pc[i+2], 1'b1, 1'b1, 32'h0);
            check("pp_head", upd_pc, seq_pc[i]);
            check("pp_no_stall", 32'(stall_to_rob), 32'd0);
            tick();
        end
        commit_valid = 1'b0;
        check("pp_rem1", upd_pc, seq_pc[6]);
        tick();
        check("pp_rem2", upd_pc, seq_pc[7]);
        check("pp_rem2_valid", 32'(upd_valid), 32'd1);
        tick();
        check("pp_empty", 32'(upd_valid), 32'd0);
        check("pp_br_count", br_count, 32'd14);

        // rdy gating during FLUSH
        upd_ready = 1'b0;
        drive_commit(32'h400, 1'b1, 1'b0, 32'h500);
        tick();
        check("rdy_flush", 32'(flush_out), 32'd1);
        rdy = 1'b0; fetch_ack = 1'b1; upd_ready = 1'b1;
        drive_commit(32'h600, 1'b0, 1'b1, 32'h700);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_hold_flush", 32'(flush_out), 32'd1);
            check("rdy_hold_redir", 32'(redirect_valid), 32'd0);
            check("rdy_hold_br", br_count, 32'd15);
            check("rdy_hold_mp", mispred_count, 32'd2);
            check("rdy_hold_head", upd_pc, 32'h400);
        end
        rdy = 1'b1; commit_valid = 1'b0; fetch_ack = 1'b0; upd_ready = 1'b0;
        tick();
        check("rdy_resume_redir", 32'(redirect_valid), 32'd1);
        check("rdy_resume_flush", 32'(flush_out), 32'd0);
        check("rdy_resume_pc", redirect_pc, 32'h500);
        check("rdy_queued", 32'(upd_valid), 32'd1);

        // Asynchronous reset mid-REDIRECT discards the sequence and the queue
        #2 rst = 1'b0;
        #1;
        check("arst_redir", 32'(redirect_valid), 32'd0);
        check("arst_upd_valid", 32'(upd_valid), 32'd0);
        check("arst_br", br_count, 32'd0);
        check("arst_mp", mispred_count, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_stall", 32'(stall_to_rob), 32'd0);
        check("arst_flush", 32'(flush_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
